hidden_instr_sequencer: RTL and testbench
=========================================

# hidden_instr_sequencer

Program store and instruction sequencer for the HiddenCPU core. It loads a short program of 6-bit instructions (opcode[1:0], ra[1:0], rb[1:0]), then replays them to the core's instruction field one per clock. It supports free run, single step, abort and absolute jumps requested by the core's branch logic. It sits between the pin interface and the core and owns every cycle the core executes.

## Interface
Parameters:
- DEPTH, 16: program store entries; power of two, 2..64.
- IW, 6: instruction width, {opcode, ra, rb}.
- AW, $clog2(DEPTH): pointer width; prog_len is AW+1 bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- mode  in  2  command: 00 idle/abort, 01 load, 10 run, 11 step.
- load_data  in  IW  instruction to store.
- load_valid  in  1  load_data is valid this cycle.
- load_ready  out  1  a store slot is available; a write happens when load_valid and load_ready are both 1.
- jump_valid  in  1  core requests a jump; sampled only in RUN.
- jump_target  in  AW  absolute program index to jump to.
- instr  out  IW  registered instruction to the core.
- instr_valid  out  1  instr is to be executed this cycle.
- state  out  2  00 IDLE, 01 LOAD, 10 RUN, 11 HALT.
- prog_len  out  AW+1  number of stored instructions.
- done  out  1  program ended normally.
- err  out  1  run ended on an out-of-range jump.

## Operation
- Reset values (immediate on rst, independent of clk): state=IDLE, instr=0, instr_valid=0, load_ready=0, done=0, err=0, prog_len=0, wptr=0, fptr=0, step_armed=1. Store contents are not reset; they are unreachable while prog_len=0.
- IDLE, mode=01: go to LOAD and set wptr=0.
- LOAD:
  - load_ready = (wptr<DEPTH).
  - On each accepted word: mem[wptr]<=load_data, wptr++.
  - When mode≠01: prog_len<=wptr, fptr<=0, go to IDLE.
  - When the store is full: load_ready=0 and load_valid is ignored; no overwrite and no wrap.
- IDLE, mode=10, prog_len≠0: enter RUN and issue mem[0] on the same edge (instr_valid<=1, fptr<=1, done<=0, err<=0). If prog_len=0, stay in IDLE.
- RUN, on each edge, highest priority first:
  1. mode=00: go to IDLE, instr_valid<=0, fptr unchanged.
  2. jump_valid with jump_target<prog_len: issue mem[jump_target], fptr<=jump_target+1.
  3. jump_valid with jump_target≥prog_len: go to HALT, instr_valid<=0, err<=1.
  4. fptr==prog_len: go to HALT, instr_valid<=0, done<=1.
  5. Otherwise: issue mem[fptr], fptr++.
- HALT: outputs hold. mode=00 returns to IDLE; done and err stay set until the next RUN entry or reset.
- IDLE, mode=11, step_armed, prog_len≠0: issue mem[fptr] for exactly one cycle and set step_armed<=0.
  - fptr advances and wraps to 0 when it reaches prog_len.
  - step_armed<=1 on any edge where mode≠11.
  - Holding mode=11 yields exactly one instruction.
- Mode values that do not apply to the current state are ignored, for example 10 in LOAD.
- jump_valid is ignored outside RUN.

## Timing
- Instruction latency: the instruction is visible on instr/instr_valid in the cycle after the edge that sampled the command. Run entry yields mem[0] at cycle 1.
- Throughput in RUN: one instruction per cycle with no bubbles, including across jumps.
- Jump: jump_valid sampled at edge N makes mem[target] visible after edge N, replacing the sequential instruction. This gives no delay slot.
- End of program: the last instruction is valid for one cycle; done rises on the following edge together with instr_valid falling.
- Load: one word per cycle. load_ready is combinational from state and wptr. prog_len updates on the edge that leaves LOAD.
- Abort (mode=00 in RUN): instr_valid falls on the next edge; no partial instruction is issued.
- rst asserted mid-RUN or mid-LOAD: outputs go to reset values without waiting for clk. prog_len is cleared, so the program must be reloaded.

## Test plan
- Load 3 words (0x05, 0x2A, 0x3F), then mode=10 → instr 0x05, 0x2A, 0x3F on three consecutive cycles with instr_valid=1; done=1 and state=HALT on the 4th.
- Load 20 words with DEPTH=16 → load_ready drops after 16 accepts; prog_len=16; words 17–20 are not stored.
- Program of 4 words, jump_valid with target=1 while issuing index 2 → sequence idx0, idx1, idx2, idx1, idx2, idx3, then done. Target=7 instead → HALT with err=1, done=0.
- Step mode with mode held at 11 for 5 cycles → exactly one instr_valid pulse. Toggle mode 11/00 four times on a 3-word program → indices 0, 1, 2, 0.
- mode=00 in the middle of RUN → instr_valid=0 next cycle, state=IDLE. Then mode=10 → restarts from index 0.
- Assert rst between clock edges during RUN → instr_valid, done, err, prog_len read 0 immediately and state=IDLE. mode=10 afterwards stays in IDLE.

Source files
------------

// File: rtl/hidden_instr_sequencer.sv
// Program store and instruction sequencer for the HiddenCPU core.
// Loads a short program, then replays it to the core in free-run or single-step fashion.
module hidden_instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int IW    = 6,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic [IW-1:0] load_data,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic          jump_valid,
  input  logic [AW-1:0] jump_target,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  output logic [1:0]    state,
  output logic [AW:0]   prog_len,
  output logic          done,
  output logic          err
);

  // IDLE: waiting for a command | LOAD: filling the store | RUN: free run | HALT: ended, outputs held
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, RUN = 2'b10, HALT = 2'b11} seqState_t;

  localparam logic [1:0]  MODE_IDLE = 2'b00;
  localparam logic [1:0]  MODE_LOAD = 2'b01;
  localparam logic [1:0]  MODE_RUN  = 2'b10;
  localparam logic [1:0]  MODE_STEP = 2'b11;
  localparam logic [AW:0] DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W     = (AW+1)'(1);

  logic [IW-1:0] mem [DEPTH];

  seqState_t     curState, nxtState;
  logic [AW:0]   wPtr, wPtrNxt, fPtr, fPtrNxt, progLenNxt;
  logic [AW:0]   stepIdx, stepIdxInc, jumpIdx;
  logic [IW-1:0] instrNxt;
  logic          validNxt, doneNxt, errNxt, stepArmed, armedNxt, wrEn;

  assign state      = curState;
  assign load_ready = (curState == LOAD) && (wPtr < DEPTH_W);
  assign wrEn       = load_valid && load_ready;
  assign jumpIdx    = {1'b0, jump_target};
  // After an abort or a finished run fPtr may sit at prog_len; stepping then restarts at 0.
  assign stepIdx    = (fPtr < prog_len) ? fPtr : '0;
  assign stepIdxInc = stepIdx + ONE_W;

  always_ff @(posedge clk) begin
    if (wrEn) mem[wPtr[AW-1:0]] <= load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curState    <= IDLE;
      wPtr        <= '0;
      fPtr        <= '0;
      prog_len    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      stepArmed   <= 1'b1;
    end else begin
      curState    <= nxtState;
      wPtr        <= wPtrNxt;
      fPtr        <= fPtrNxt;
      prog_len    <= progLenNxt;
      instr       <= instrNxt;
      instr_valid <= validNxt;
      done        <= doneNxt;
      err         <= errNxt;
      stepArmed   <= armedNxt;
    end
  end

  always_comb begin
    nxtState   = curState;
    wPtrNxt    = wPtr;
    fPtrNxt    = fPtr;
    progLenNxt = prog_len;
    instrNxt   = instr;
    validNxt   = 1'b0;
    doneNxt    = done;
    errNxt     = err;
    armedNxt   = (mode != MODE_STEP) ? 1'b1 : stepArmed;
    unique case (curState)
      IDLE: begin
        if (mode == MODE_LOAD) begin
          nxtState = LOAD;
          wPtrNxt  = '0;
        end else if (mode == MODE_RUN && prog_len != '0) begin
          nxtState = RUN;
          instrNxt = mem[0];
          validNxt = 1'b1;
          fPtrNxt  = ONE_W;
          doneNxt  = 1'b0;
          errNxt   = 1'b0;
        end else if (mode == MODE_STEP && stepArmed && prog_len != '0) begin
          instrNxt = mem[stepIdx[AW-1:0]];
          validNxt = 1'b1;
          armedNxt = 1'b0;
          fPtrNxt  = (stepIdxInc == prog_len) ? '0 : stepIdxInc;
        end
      end
      LOAD: begin
        if (wrEn) wPtrNxt = wPtr + ONE_W;
        if (mode != MODE_LOAD) begin
          progLenNxt = wPtr;
          fPtrNxt    = '0;
          nxtState   = IDLE;
        end
      end
      RUN: begin
        if (mode == MODE_IDLE) begin
          nxtState = IDLE;
        end else if (jump_valid && jumpIdx < prog_len) begin
          instrNxt = mem[jump_target];
          validNxt = 1'b1;
          fPtrNxt  = jumpIdx + ONE_W;
        end else if (jump_valid) begin
          nxtState = HALT;
          errNxt   = 1'b1;
        end else if (fPtr == prog_len) begin
          nxtState = HALT;
          doneNxt  = 1'b1;
        end else begin
          instrNxt = mem[fPtr[AW-1:0]];
          validNxt = 1'b1;
          fPtrNxt  = fPtr + ONE_W;
        end
      end
      HALT: begin
        if (mode == MODE_IDLE) nxtState = IDLE;
      end
      default: nxtState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hidden_instr_sequencer.sv
// Bench for hidden_instr_sequencer: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a behavioural model of the sequencer.
module tb_hidden_instr_sequencer;
  localparam int DEPTH = 16;
  localparam int IW    = 6;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic [IW-1:0] load_data = '0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic          jump_valid = 1'b0;
  logic [AW-1:0] jump_target = '0;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic [1:0]    state;
  logic [AW:0]   prog_len;
  logic          done;
  logic          err;

  hidden_instr_sequencer #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .instr(instr), .instr_valid(instr_valid), .state(state),
    .prog_len(prog_len), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int nPass  = 0;
  int nTotal = 0;
  bit chkOn  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: program image, length, phase (numbered as the state port reports it)
  // and fetch index, advanced once per rising edge from the inputs seen at that edge.
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_HALT = 3;
  int mMem [DEPTH];
  int mPhase, mLen, mW, mF, mInstr;
  bit mArmed, mValid, mDone, mErr;

  task automatic modelEdge();
    int m, oldW, idx;
    bit v, armNext;
    m = int'(mode);
    v = 1'b0;
    armNext = (m != 3) ? 1'b1 : mArmed;
    case (mPhase)
      P_IDLE: begin
        if (m == 1) begin
          mPhase = P_LOAD; mW = 0;
        end else if (m == 2 && mLen > 0) begin
          mPhase = P_RUN; mInstr = mMem[0]; v = 1'b1; mF = 1; mDone = 1'b0; mErr = 1'b0;
        end else if (m == 3 && mArmed && mLen > 0) begin
          idx = (mF < mLen) ? mF : 0;
          mInstr = mMem[idx]; v = 1'b1; mF = (idx + 1) % mLen; armNext = 1'b0;
        end
      end
      P_LOAD: begin
        oldW = mW;
        if (load_valid && mW < DEPTH) begin mMem[mW] = int'(load_data); mW++; end
        if (m != 1) begin mLen = oldW; mF = 0; mPhase = P_IDLE; end
      end
      P_RUN: begin
        if (m == 0) mPhase = P_IDLE;
        else if (jump_valid && int'(jump_target) < mLen) begin
          mInstr = mMem[jump_target]; v = 1'b1; mF = int'(jump_target) + 1;
        end else if (jump_valid) begin
          mPhase = P_HALT; mErr = 1'b1;
        end else if (mF == mLen) begin
          mPhase = P_HALT; mDone = 1'b1;
        end else begin
          mInstr = mMem[mF]; v = 1'b1; mF++;
        end
      end
      default: if (m == 0) mPhase = P_IDLE;
    endcase
    mValid = v;
    mArmed = armNext;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPhase = P_IDLE; mLen = 0; mW = 0; mF = 0; mInstr = 0;
      mArmed = 1'b1; mValid = 1'b0; mDone = 1'b0; mErr = 1'b0;
    end else begin
      modelEdge();
    end
  end

  always @(negedge clk) begin
    if (chkOn && !rst) begin
      check("state", state, mPhase);
      check("instr_valid", instr_valid, mValid);
      if (mValid) check("instr", instr, mInstr);
      check("done", done, mDone);
      check("err", err, mErr);
      check("prog_len", prog_len, mLen);
      check("load_ready", load_ready, (mPhase == P_LOAD && mW < DEPTH));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic loadWords(input logic [IW-1:0] w[$]);
    mode = 2'b01;
    tick();
    foreach (w[i]) begin
      load_data = w[i]; load_valid = 1'b1;
      tick();
    end
    load_valid = 1'b0; mode = 2'b00;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [IW-1:0] q[$];
    logic [IW-1:0] stepExp[4];
    int acc, pulses, hold;

    #12;
    check("rst_state", state, 0);
    check("rst_instr", instr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_prog_len", prog_len, 0);
    @(posedge clk); #1;
    rst = 1'b0; chkOn = 1'b1;

    // Three-word program, free run to completion
    q = '{6'h05, 6'h2A, 6'h3F};
    loadWords(q);
    check("load3_prog_len", prog_len, 3);
    mode = 2'b10;
    tick(); check("run_w0", {instr_valid, instr}, {1'b1, 6'h05});
    tick(); check("run_w1", {instr_valid, instr}, {1'b1, 6'h2A});
    tick(); check("run_w2", {instr_valid, instr}, {1'b1, 6'h3F});
    tick(); check("run_end", {instr_valid, done, err, state}, {1'b0, 1'b1, 1'b0, 2'b11});
    mode = 2'b00; tick();

    // Overfill: 20 offered, 16 accepted
    mode = 2'b01; tick();
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      load_data = IW'($urandom); load_valid = 1'b1;
      acc += int'(load_ready);
      tick();
    end
    check("full_load_ready", load_ready, 0);
    check("full_accepts", acc, 16);
    load_valid = 1'b0; mode = 2'b00; tick();
    check("full_prog_len", prog_len, 16);
    mode = 2'b10; tick(17);
    check("full_done", done, 1);
    mode = 2'b00; tick();

    // Jump back inside the program, then out of range
    q = '{6'h11, 6'h22, 6'h33, 6'h04};
    loadWords(q);
    mode = 2'b10;
    tick(); check("jmp_i0", instr, 6'h11);
    tick(); check("jmp_i1", instr, 6'h22);
    tick(); check("jmp_i2", instr, 6'h33);
    jump_valid = 1'b1; jump_target = 4'd1;
    tick(); check("jmp_tgt", {instr_valid, instr}, {1'b1, 6'h22});
    jump_valid = 1'b0;
    tick(); check("jmp_i2b", instr, 6'h33);
    tick(); check("jmp_i3", instr, 6'h04);
    tick(); check("jmp_done", {instr_valid, done}, 2'b01);
    mode = 2'b00; tick();
    mode = 2'b10; tick(3);
    jump_valid = 1'b1; jump_target = 4'd7;
    tick(); check("jmp_oor", {instr_valid, done, err, state}, {1'b0, 1'b0, 1'b1, 2'b11});
    jump_valid = 1'b0; mode = 2'b00; tick();

    // Single step with wrap, then a held step command
    q = '{6'h0A, 6'h15, 6'h2B};
    loadWords(q);
    stepExp = '{6'h0A, 6'h15, 6'h2B, 6'h0A};
    for (int k = 0; k < 4; k++) begin
      mode = 2'b11; tick();
      check($sformatf("step%0d", k), {instr_valid, instr}, {1'b1, stepExp[k]});
      mode = 2'b00; tick();
      check($sformatf("step%0d_off", k), instr_valid, 0);
    end
    mode = 2'b11; pulses = 0;
    repeat (5) begin tick(); pulses += int'(instr_valid); end
    check("step_held_pulses", pulses, 1);
    mode = 2'b00; tick();

    // Abort mid-run, then restart from index 0
    mode = 2'b10; tick(2);
    mode = 2'b00; tick();
    check("abort", {instr_valid, state}, 3'b000);
    mode = 2'b10; tick();
    check("restart", {instr_valid, instr}, {1'b1, 6'h0A});
    mode = 2'b00; tick();

    // Asynchronous reset between edges during a run
    mode = 2'b10; tick(2);
    #2 rst = 1'b1;
    #1;
    check("arst", {instr_valid, done, err, state, prog_len}, '0);
    tick();
    rst = 1'b0;
    tick();
    check("arst_no_run", state, 0);
    mode = 2'b00; tick();

    // Randomized traffic
    hold = 0;
    for (int c = 0; c < 2500; c++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2: mode = 2'b01;
          3, 4, 5: mode = 2'b10;
          6, 7:    mode = 2'b11;
          default: mode = 2'b00;
        endcase
        hold = (mode == 2'b10) ? $urandom_range(1, 30) : $urandom_range(1, 12);
      end
      hold--;
      load_valid  = (mode == 2'b01) ? 1'($urandom_range(0, 1)) : 1'b0;
      load_data   = IW'($urandom);
      jump_valid  = ($urandom_range(0, 7) == 0);
      jump_target = AW'($urandom);
      tick();
    end

    chkOn = 1'b0;
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
